// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM: decodes opcode/funct, sequences
// FETCH/DECODE/EXEC/MEM/WB, traps on illegal work and counts retired instructions.
module mc_controller #(
  parameter bit          MEM_WAIT  = 1'b1,
  parameter bit          ADDI_TRAP = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             rs_neg,
  input  logic             ovf,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             ALUSrc,
  output logic [1:0]       npc_sel,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       Extop,
  output logic [2:0]       ALUctr,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_LW, I_SW, I_BEQ,
    I_LUI, I_J, I_ADDI, I_ADDIU, I_JAL, I_BGEZAL, I_ILL
  } instr_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_BGEZAL = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_ADDU   = 6'b100001;
  localparam logic [5:0] FN_SUBU   = 6'b100011;
  localparam logic [5:0] FN_SLT    = 6'b101010;

  state_t           state_q, state_d;
  instr_t           instr;
  logic             ready;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic [2:0]       alu_ctr;
  logic             alu_src;
  logic [1:0]       ext_op;

  assign ready   = !MEM_WAIT || mem_ready;
  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

  // Instruction classification from the held IR fields
  always_comb begin
    instr = I_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: instr = I_ADDU;
          FN_SUBU: instr = I_SUBU;
          FN_SLT:  instr = I_SLT;
          FN_JR:   instr = I_JR;
          default: instr = I_ILL;
        endcase
      end
      OP_BGEZAL: instr = I_BGEZAL;
      OP_J:      instr = I_J;
      OP_JAL:    instr = I_JAL;
      OP_BEQ:    instr = I_BEQ;
      OP_ADDI:   instr = I_ADDI;
      OP_ADDIU:  instr = I_ADDIU;
      OP_ORI:    instr = I_ORI;
      OP_LUI:    instr = I_LUI;
      OP_LW:     instr = I_LW;
      OP_SW:     instr = I_SW;
      default:   instr = I_ILL;
    endcase
  end

  // Datapath ALU/extender setup, driven from EXEC through WB
  always_comb begin
    alu_ctr = 3'b001;
    alu_src = 1'b0;
    ext_op  = 2'b00;
    case (instr)
      I_SUBU: alu_ctr = 3'b010;
      I_SLT:  alu_ctr = 3'b011;
      I_BEQ:  alu_ctr = 3'b010;
      I_ORI: begin
        alu_ctr = 3'b100;
        alu_src = 1'b1;
      end
      I_LUI: begin
        alu_ctr = 3'b000;
        alu_src = 1'b1;
        ext_op  = 2'b01;
      end
      I_ADDI, I_ADDIU, I_LW, I_SW: begin
        alu_src = 1'b1;
        ext_op  = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ALUSrc     = 1'b0;
    npc_sel    = 2'b00;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    Extop      = 2'b00;
    ALUctr     = 3'b000;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_re = 1'b1;
        if (ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (instr)
          I_ILL: state_d = S_TRAP;
          I_J: begin
            pc_we      = 1'b1;
            npc_sel    = 2'b10;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          I_JAL: begin
            pc_we      = 1'b1;
            npc_sel    = 2'b10;
            reg_we     = 1'b1;
            RegDst     = 2'b10;
            MemtoReg   = 2'b10;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          I_JR: begin
            pc_we      = 1'b1;
            npc_sel    = 2'b11;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ALUctr = alu_ctr;
        ALUSrc = alu_src;
        Extop  = ext_op;
        case (instr)
          I_BEQ: begin
            pc_we      = zero;
            npc_sel    = 2'b01;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          // Link register is written whether or not the branch is taken
          I_BGEZAL: begin
            pc_we      = ~rs_neg;
            npc_sel    = 2'b01;
            reg_we     = 1'b1;
            RegDst     = 2'b10;
            MemtoReg   = 2'b10;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          I_LW, I_SW: state_d = S_MEM;
          I_ADDI:     state_d = (ADDI_TRAP && ovf) ? S_TRAP : S_WB;
          I_ADDU, I_SUBU, I_SLT, I_ORI, I_LUI, I_ADDIU: state_d = S_WB;
          default:    state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        ALUctr = alu_ctr;
        ALUSrc = alu_src;
        Extop  = ext_op;
        case (instr)
          I_LW: begin
            mem_re = 1'b1;
            if (ready) state_d = S_WB;
          end
          I_SW: begin
            mem_we = 1'b1;
            if (ready) begin
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_WB: begin
        ALUctr     = alu_ctr;
        ALUSrc     = alu_src;
        Extop      = ext_op;
        reg_we     = 1'b1;
        RegDst     = (instr == I_ADDU || instr == I_SUBU || instr == I_SLT) ? 2'b01 : 2'b00;
        MemtoReg   = (instr == I_LW) ? 2'b01 : 2'b00;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Sticky trap flag and wrapping retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (state_d == S_TRAP) illegal_q <= 1'b1;
      if (instr_done) retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed and random instruction streams, each expanded
// into its expected phase sequence and compared cycle by cycle.
module tb_mc_controller;

  localparam logic [5:0] OP_R      = 6'b000000;
  localparam logic [5:0] OP_BGEZAL = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_ADDU   = 6'b100001;
  localparam logic [5:0] FN_SUBU   = 6'b100011;
  localparam logic [5:0] FN_SLT    = 6'b101010;

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BGEZAL = 4;
  localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8, K_ADDI = 9;

  // mux vector: {RegDst, MemtoReg, Extop, ALUctr, ALUSrc}
  localparam logic [9:0] M_WB = 10'b11_11_00_000_0;
  localparam logic [9:0] M_AE = 10'b00_00_11_111_1;
  localparam logic [9:0] M_A  = 10'b00_00_00_111_1;

  typedef struct packed {
    logic [2:0] st;
    logic       pc, ir, rw, re, we;
    logic [1:0] npc;
    logic       done;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode, funct;
  logic zero, rs_neg, ovf, mem_ready;

  logic pc_we0, ir_we0, reg_we0, mem_re0, mem_we0, alusrc0, done0, ill0;
  logic [1:0] npc0, rd0, m2r0, ext0;
  logic [2:0] alu0, st0;
  logic [31:0] ret0;
  logic pc_we1, ir_we1, reg_we1, mem_re1, mem_we1, alusrc1, done1, ill1;
  logic [1:0] npc1, rd1, m2r1, ext1;
  logic [2:0] alu1, st1;
  logic [31:0] ret1;
  logic pc_we2, ir_we2, reg_we2, mem_re2, mem_we2, alusrc2, done2, ill2;
  logic [1:0] npc2, rd2, m2r2, ext2;
  logic [2:0] alu2, st2;
  logic [3:0] ret2;

  int checks = 0;
  int errors = 0;
  int unsigned model_ret;
  bit model_ill;

  ctl_t       eq[$];
  logic [9:0] mx[$];
  logic [9:0] mm[$];
  bit         rq[$];

  mc_controller u0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .rs_neg(rs_neg),
    .ovf(ovf), .mem_ready(mem_ready), .pc_we(pc_we0), .ir_we(ir_we0), .reg_we(reg_we0),
    .mem_re(mem_re0), .mem_we(mem_we0), .ALUSrc(alusrc0), .npc_sel(npc0), .RegDst(rd0),
    .MemtoReg(m2r0), .Extop(ext0), .ALUctr(alu0), .instr_done(done0), .illegal(ill0),
    .retired(ret0), .state(st0));

  mc_controller #(.ADDI_TRAP(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .rs_neg(rs_neg),
    .ovf(ovf), .mem_ready(mem_ready), .pc_we(pc_we1), .ir_we(ir_we1), .reg_we(reg_we1),
    .mem_re(mem_re1), .mem_we(mem_we1), .ALUSrc(alusrc1), .npc_sel(npc1), .RegDst(rd1),
    .MemtoReg(m2r1), .Extop(ext1), .ALUctr(alu1), .instr_done(done1), .illegal(ill1),
    .retired(ret1), .state(st1));

  mc_controller #(.CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .rs_neg(rs_neg),
    .ovf(ovf), .mem_ready(mem_ready), .pc_we(pc_we2), .ir_we(ir_we2), .reg_we(reg_we2),
    .mem_re(mem_re2), .mem_we(mem_we2), .ALUSrc(alusrc2), .npc_sel(npc2), .RegDst(rd2),
    .MemtoReg(m2r2), .Extop(ext2), .ALUctr(alu2), .instr_done(done2), .illegal(ill2),
    .retired(ret2), .state(st2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t mk(int st, int pc, int ir, int rw, int re, int we, int npc, int done);
    ctl_t c;
    c.st = 3'(st); c.pc = 1'(pc); c.ir = 1'(ir); c.rw = 1'(rw);
    c.re = 1'(re); c.we = 1'(we); c.npc = 2'(npc); c.done = 1'(done);
    return c;
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_R: begin
        if (fn == FN_ADDU || fn == FN_SUBU || fn == FN_SLT) return K_ALU;
        if (fn == FN_JR) return K_JR;
        return K_ILL;
      end
      OP_ORI, OP_LUI, OP_ADDIU: return K_ALU;
      OP_ADDI:   return K_ADDI;
      OP_LW:     return K_LW;
      OP_SW:     return K_SW;
      OP_BEQ:    return K_BEQ;
      OP_BGEZAL: return K_BGEZAL;
      OP_J:      return K_J;
      OP_JAL:    return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  // Expected ALU/extender setup and which of those fields are defined
  function automatic void alu_expect(input logic [5:0] op, input logic [5:0] fn,
                                     output logic [9:0] ax, output logic [9:0] am);
    ax = '0;
    am = M_A;
    case (op)
      OP_R: begin
        if (fn == FN_ADDU) ax[3:1] = 3'd1;
        else if (fn == FN_SUBU) ax[3:1] = 3'd2;
        else if (fn == FN_SLT) ax[3:1] = 3'd3;
        else am = '0;
      end
      OP_ORI: begin ax = {4'b0, 2'b00, 3'd4, 1'b1}; am = M_AE; end
      OP_LUI: begin ax = {4'b0, 2'b01, 3'd0, 1'b1}; am = M_AE; end
      OP_ADDI, OP_ADDIU: ax = {4'b0, 2'b00, 3'd1, 1'b1};
      OP_LW, OP_SW: begin ax = {4'b0, 2'b10, 3'd1, 1'b1}; am = M_AE; end
      OP_BEQ: ax[3:1] = 3'd2;
      default: am = '0;
    endcase
  endfunction

  task automatic push(input ctl_t c, input logic [9:0] x, input logic [9:0] m, input bit r);
    eq.push_back(c);
    mx.push_back(x);
    mm.push_back(m);
    rq.push_back(r);
  endtask

  // Expand one instruction into its cycle sequence, then drive and compare u0
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z, input bit neg,
                           input bit of, input int fst, input int mst, input int extra);
    int k;
    bit trap;
    logic [9:0] ax, am;
    logic [1:0] rdx;
    k = classify(op, fn);
    alu_expect(op, fn, ax, am);
    rdx = (op == OP_R) ? 2'b01 : 2'b00;
    trap = (k == K_ILL) || (k == K_ADDI && of);
    eq.delete(); mx.delete(); mm.delete(); rq.delete();
    for (int i = 0; i < fst; i++) push(mk(0, 0, 0, 0, 1, 0, 0, 0), '0, '0, 1'b0);
    push(mk(0, 1, 1, 0, 1, 0, 0, 0), '0, '0, 1'b1);
    case (k)
      K_ILL: push(mk(1, 0, 0, 0, 0, 0, 0, 0), '0, '0, 1'b1);
      K_J:   push(mk(1, 1, 0, 0, 0, 0, 2, 1), '0, '0, 1'b1);
      K_JAL: push(mk(1, 1, 0, 1, 0, 0, 2, 1), {2'b10, 2'b10, 6'b0}, M_WB, 1'b1);
      K_JR:  push(mk(1, 1, 0, 0, 0, 0, 3, 1), '0, '0, 1'b1);
      default: begin
        push(mk(1, 0, 0, 0, 0, 0, 0, 0), '0, '0, 1'b1);
        case (k)
          K_BEQ: push(mk(2, int'(z), 0, 0, 0, 0, 1, 1), ax, am, 1'b1);
          K_BGEZAL: push(mk(2, int'(!neg), 0, 1, 0, 0, 1, 1), {2'b10, 2'b10, 6'b0}, M_WB, 1'b1);
          K_LW, K_SW: begin
            push(mk(2, 0, 0, 0, 0, 0, 0, 0), ax, am, 1'b1);
            for (int i = 0; i < mst; i++)
              push(mk(3, 0, 0, 0, int'(k == K_LW), int'(k == K_SW), 0, 0), '0, '0, 1'b0);
            push(mk(3, 0, 0, 0, int'(k == K_LW), int'(k == K_SW), 0, int'(k == K_SW)), '0, '0, 1'b1);
            if (k == K_LW) push(mk(4, 0, 0, 1, 0, 0, 0, 1), {2'b00, 2'b01, 6'b0}, M_WB, 1'b1);
          end
          default: begin
            push(mk(2, 0, 0, 0, 0, 0, 0, 0), ax, am, 1'b1);
            if (!trap) push(mk(4, 0, 0, 1, 0, 0, 0, 1), {rdx, 2'b00, ax[5:0]}, M_WB | am, 1'b1);
          end
        endcase
      end
    endcase
    if (trap) for (int i = 0; i <= extra; i++) push(mk(5, 0, 0, 0, 0, 0, 0, 0), '0, '0, 1'b1);

    foreach (eq[i]) begin
      opcode = op; funct = fn; zero = z; rs_neg = neg; ovf = of; mem_ready = rq[i];
      @(negedge clk);
      if (eq[i].st == 3'd5) model_ill = 1'b1;
      chk("ctl", 32'({st0, pc_we0, ir_we0, reg_we0, mem_re0, mem_we0, npc0, done0}), 32'(eq[i]));
      chk("retired", ret0, model_ret);
      chk("illegal", 32'(ill0), 32'(model_ill));
      if (mm[i] != '0)
        chk("mux", 32'({rd0, m2r0, ext0, alu0, alusrc0} & mm[i]), 32'(mx[i] & mm[i]));
      if (eq[i].done) model_ret++;
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_ret = 0;
    model_ill = 1'b0;
    @(negedge clk);
    chk("rst_state", 32'(st0), 32'd0);
    chk("rst_illegal", 32'(ill0), 32'd0);
    chk("rst_retired", ret0, 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  logic [5:0] rops[14];
  logic [5:0] rfns[14];

  initial begin
    int idx;
    logic [5:0] op, fn;
    rops = '{OP_R, OP_R, OP_R, OP_R, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_J,
             OP_ADDI, OP_ADDIU, OP_JAL, OP_BGEZAL};
    rfns = '{FN_ADDU, FN_SUBU, FN_SLT, FN_JR, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
             6'd0, 6'd0, 6'd0, 6'd0};
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; rs_neg = 1'b0; ovf = 1'b0; mem_ready = 1'b0;
    do_reset();

    // addu straight through, then explicit retired count
    run_instr(OP_R, FN_ADDU, 0, 0, 0, 0, 0, 0);
    chk("addu_retired", ret0, 32'd1);
    run_instr(OP_LW, 6'd0, 0, 0, 0, 0, 3, 0);
    run_instr(OP_BEQ, 6'd0, 0, 0, 0, 0, 0, 0);
    run_instr(OP_BEQ, 6'd0, 1, 0, 0, 0, 0, 0);
    chk("beq_retired", ret0, 32'd4);
    run_instr(OP_SW, 6'd0, 0, 0, 0, 1, 2, 0);
    run_instr(OP_J, 6'd0, 0, 0, 0, 0, 0, 0);
    run_instr(OP_JAL, 6'd0, 0, 0, 0, 2, 0, 0);
    run_instr(OP_R, FN_JR, 0, 0, 0, 0, 0, 0);
    run_instr(OP_BGEZAL, 6'd0, 0, 0, 0, 0, 0, 0);
    run_instr(OP_BGEZAL, 6'd0, 0, 1, 0, 0, 0, 0);
    run_instr(OP_ORI, 6'd0, 0, 0, 0, 0, 0, 0);
    run_instr(OP_LUI, 6'd0, 0, 0, 0, 0, 0, 0);
    run_instr(OP_R, FN_SUBU, 0, 0, 0, 0, 0, 0);
    run_instr(OP_R, FN_SLT, 0, 0, 0, 0, 0, 0);
    run_instr(OP_ADDIU, 6'd0, 0, 0, 1, 0, 0, 0);
    run_instr(OP_ADDI, 6'd0, 0, 0, 0, 0, 0, 0);

    // Random legal stream with random stalls
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 13);
      op = rops[idx];
      fn = (op == OP_R) ? rfns[idx] : 6'($urandom);
      run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                (op == OP_ADDI) ? 1'b0 : 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3), 0);
    end

    // Asynchronous reset in the middle of a load stall
    run_instr(OP_R, FN_JR, 0, 0, 0, 0, 0, 0);
    opcode = OP_LW; funct = '0; mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    chk("stall_state", 32'(st0), 32'd3);
    chk("stall_mem_re", 32'(mem_re0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", 32'(st0), 32'd0);
    chk("async_retired", ret0, 32'd0);
    chk("async_retired4", 32'(ret2), 32'd0);
    tick();
    rst_n = 1'b1;
    model_ret = 0;
    model_ill = 1'b0;
    run_instr(OP_R, FN_ADDU, 0, 0, 0, 0, 0, 0);

    // addi overflow: trapping vs non-trapping variant side by side
    opcode = OP_ADDI; funct = '0; ovf = 1'b1; mem_ready = 1'b1; zero = 1'b0; rs_neg = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("addi_trap_state", 32'(st0), 32'd5);
    chk("addi_trap_illegal", 32'(ill0), 32'd1);
    chk("addi_trap_reg_we", 32'(reg_we0), 32'd0);
    chk("addi_trap_retired", ret0, model_ret);
    chk("addi_wb_state", 32'(st1), 32'd4);
    chk("addi_wb_reg_we", 32'(reg_we1), 32'd1);
    chk("addi_wb_done", 32'(done1), 32'd1);
    tick();
    @(negedge clk);
    chk("addi_trap_hold", 32'(st0), 32'd5);
    chk("addi_wb_next", 32'(st1), 32'd0);
    tick();
    ovf = 1'b0;
    do_reset();

    // Illegal opcodes trap and freeze the counter
    run_instr(OP_R, FN_JR, 0, 0, 0, 0, 0, 0);
    run_instr(6'b111111, 6'd0, 0, 0, 0, 0, 0, 3);
    do_reset();
    run_instr(OP_R, 6'b000000, 0, 0, 0, 1, 0, 1);
    do_reset();

    // Narrow counter wraps 15 -> 0
    for (int n = 0; n < 15; n++) run_instr(OP_R, FN_JR, 0, 0, 0, 0, 0, 0);
    chk("wrap_15", 32'(ret2), 32'd15);
    run_instr(OP_R, FN_JR, 0, 0, 0, 0, 0, 0);
    chk("wrap_0", 32'(ret2), 32'd0);
    chk("wide_16", ret0, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
